// File: rtl/addsub_pkg.sv
// addsub_pkg: shared width default and NZCV flag record for the pipelined adder/subtractor
package addsub_pkg;
  localparam int WIDTH_DEFAULT = 64;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
endpackage

// File: rtl/addsub_if.sv
// addsub_if: operand-side and result-side valid/ready handshake of addsub_pipe
interface addsub_if #(parameter int WIDTH = addsub_pkg::WIDTH_DEFAULT);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational N-bit adder with carry in and carry out
module addsub_chunk #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage add/sub, low half in stage 1, high half plus NZCV in stage 2
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SPLIT = 32
) (
  input logic     clk,
  input logic     rst_n,
  addsub_if.slave io
);
  localparam int H = WIDTH - SPLIT;
  logic             s1_valid, s2_valid, s1_adv, s2_adv;
  logic [WIDTH-1:0] bx, res_q;
  logic [SPLIT-1:0] lo_sum, lo_q;
  logic             c_mid, c_mid_q, c_hi;
  logic [H-1:0]     a_hi_q, bx_hi_q, hi_sum;
  nzcv_t            flags_d, flags_q;
  assign bx     = io.sub ? ~io.b : io.b;
  assign s2_adv = !s2_valid || io.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  addsub_chunk #(.N(SPLIT)) u_lo (
    .a(io.a[SPLIT-1:0]), .b(bx[SPLIT-1:0]), .cin(io.sub), .s(lo_sum), .cout(c_mid)
  );
  addsub_chunk #(.N(H)) u_hi (
    .a(a_hi_q), .b(bx_hi_q), .cin(c_mid_q), .s(hi_sum), .cout(c_hi)
  );
  always_comb begin
    flags_d.n = hi_sum[H-1];
    flags_d.z = ({hi_sum, lo_q} == '0);
    flags_d.c = c_hi;
    flags_d.v = (a_hi_q[H-1] == bx_hi_q[H-1]) && (hi_sum[H-1] != a_hi_q[H-1]);
  end
  // stage-1 data is qualified by s1_valid, so it needs no reset
  always_ff @(posedge clk)
    if (io.in_valid && s1_adv) begin
      lo_q    <= lo_sum;
      c_mid_q <= c_mid;
      a_hi_q  <= io.a[WIDTH-1:SPLIT];
      bx_hi_q <= bx[WIDTH-1:SPLIT];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      if (s1_adv) s1_valid <= io.in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_valid && s2_adv) begin
        res_q   <= {hi_sum, lo_q};
        flags_q <= flags_d;
      end
    end
  assign io.in_ready  = s1_adv;
  assign io.out_valid = s2_valid;
  assign io.result    = res_q;
  assign io.flag_n    = flags_q.n;
  assign io.flag_z    = flags_q.z;
  assign io.flag_c    = flags_q.c;
  assign io.flag_v    = flags_q.v;
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- 64-bit, two-stage pipelined adder/subtractor with a valid/ready handshake on both sides.
- Produces the result together with NZCV condition flags.
- Complements the combinational datapath adder: multi-cycle ALU paths use it where a full 64-bit carry chain does not close timing in one cycle.
- Supplies results and flags to the execute/flag-writeback stage.

Parameters:
- WIDTH, 64, operand and result width in bits.
- SPLIT, 32, bit position of the stage boundary. Stage 1 computes bits [SPLIT-1:0]; stage 2 computes bits [WIDTH-1:SPLIT]. Legal range 1..WIDTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- sub  in  1  0: a+b; 1: a-b (computed as a+~b+1).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- flag_n  out  1  result[WIDTH-1].
- flag_z  out  1  result == 0.
- flag_c  out  1  carry out of bit WIDTH-1. For sub this is 1 when there is no borrow (a >= b unsigned).
- flag_v  out  1  signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - s1_valid=0 and s2_valid=0.
  - out_valid=0, result=0, all flags=0.
  - in_ready=1 while rst_n=1 and the pipe is empty.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 register, loaded on input transfer:
  - lo_sum = a[SPLIT-1:0] + bx[SPLIT-1:0] + sub, where bx = sub ? ~b : b.
  - Captures lo_sum, the carry out of bit SPLIT-1, a[WIDTH-1:SPLIT], and bx[WIDTH-1:SPLIT].
- Stage 2 register, loaded when s1_valid and stage 2 advances:
  - hi_sum = a_hi + bx_hi + c_mid.
  - Captures result = {hi_sum, lo_sum} and all four flags.
- Flags:
  - flag_c is the carry out of hi_sum.
  - flag_v = (a_hi[msb] == bx_hi[msb]) && (hi_sum[msb] != a_hi[msb]).
  - Flags are computed in stage 2 and registered with the result. They are never combinational from the inputs.
- Advance conditions:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is the only combinational path from out_ready to in_ready and is permitted.
- Occupancy updates:
  - s2_valid next = s1_valid when s2_adv; otherwise it holds.
  - s1_valid next = in_valid when s1_adv; otherwise it holds.
- Latency and throughput:
  - out_valid rises 2 cycles after the input transfer when out_ready is held high.
  - Throughput is 1 operation per cycle.
- Stall:
  - While out_valid && !out_ready, result and flags hold stable.
  - Stage 1 fills to at most one entry; then in_ready=0.
  - No data is dropped or duplicated; capacity is 2 in flight.
- Simultaneous events: when full with out_ready=1 and in_valid=1, all three transfers happen in the same cycle with no bubble.
- Reset mid-operation: all in-flight operations are discarded and out_valid drops immediately (asynchronous).
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only through flag_c and flag_v.
- Data registers need no reset beyond result/flags. The valid bits are the only control state.

Decomposition:
- Package addsub_pkg holds:
  - constant WIDTH_DEFAULT=64.
  - typedef struct packed {n,z,c,v} nzcv_t, used for the flag register and by downstream consumers.
- Sub-module addsub_chunk: a combinational N-bit adder with cin/cout, instantiated twice (N=SPLIT and N=WIDTH-SPLIT).

Test Plan:
- Add: a=0x1234567890ABCDEF, b=0xFEDCBA0987654321, sub=0, out_ready=1. Expect result=0x1111108218111110 and N=0 Z=0 C=1 V=0, with out_valid exactly 2 cycles after the input transfer.
- Sub, no borrow: a=5, b=3, sub=1. Expect result=2, C=1, N=0, Z=0.
- Sub, borrow: a=3, b=5, sub=1. Expect result=0xFFFFFFFFFFFFFFFE, C=0, N=1.
- Equal operands: a=5, b=5, sub=1. Expect Z=1, C=1.
- Overflow: a=0x7FFFFFFFFFFFFFFF, b=1, sub=0. Expect result=0x8000000000000000, V=1, N=1, C=0.
- Backpressure: hold out_ready=0 and offer 3 back-to-back ops. Expect:
  - ops 1 and 2 accepted, then in_ready=0;
  - outputs stable;
  - on out_ready=1, ops 1..3 emerge in order on consecutive cycles with correct values.
- Reset mid-operation: assert rst_n=0 between clock edges with 2 ops in flight. Expect out_valid=0 immediately and no stale result after release.
